// File: rtl/vote_display_ctrl.sv
// Drives the voting machine's seven-segment decoder: "CONF" after each vote, rotating tallies
// in results mode, blank otherwise. Define VOTE_DISP_CAND_INDEX_EN to show the candidate number.
module vote_display_ctrl #(
    parameter int unsigned NUM_CAND     = 4,
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned CONF_CYCLES  = 100000000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vote_pulse,
    input  logic                    results_en,
    input  logic [16*NUM_CAND-1:0]  tally_bus,
    output logic [16:0]             disp_in,
    output logic [2:0]              disp_mode,
    output logic [2:0]              cand_sel,
    output logic                    busy
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StConfirm = 2'b01,
        StResults = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] ConfLast  = CNT_W'(CONF_CYCLES - 1);
    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimerMax  = {CNT_W{1'b1}};
    localparam logic [2:0]       LastCand  = 3'(NUM_CAND - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d, timer_inc;
    logic [2:0]        cand_d;
    logic [15:0]       tally_arr [8];
    logic [15:0]       tally_sel;
    logic [16:0]       res_val;

    // Unused slots read as zero so a 3-bit index is always in range.
    for (genvar i = 0; i < 8; i++) begin : g_tally
        if (i < NUM_CAND) begin : g_used
            assign tally_arr[i] = tally_bus[16*i +: 16];
        end else begin : g_unused
            assign tally_arr[i] = '0;
        end
    end

    assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cand_d  = cand_sel;
        if (vote_pulse) begin
            state_d = StConfirm;
            timer_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (results_en) begin
                        state_d = StResults;
                        timer_d = '0;
                        cand_d  = '0;
                    end
                end
                StConfirm: begin
                    if (timer_q == ConfLast) begin
                        state_d = results_en ? StResults : StIdle;
                        timer_d = '0;
                        if (results_en) cand_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                StResults: begin
                    if (!results_en) begin
                        state_d = StIdle;
                        timer_d = '0;
                        cand_d  = '0;
                    end else if (timer_q == DwellLast) begin
                        timer_d = '0;
                        cand_d  = (cand_sel == LastCand) ? 3'd0 : cand_sel + 3'd1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                    cand_d  = '0;
                end
            endcase
        end
    end

    assign tally_sel = tally_arr[cand_d];

`ifdef VOTE_DISP_CAND_INDEX_EN
    assign res_val = {1'b0, {1'b0, cand_d} + 4'd1, tally_sel[11:0]};
`else
    assign res_val = {1'b0, tally_sel};
`endif

    // Outputs follow the next state so they line up with the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            cand_sel  <= '0;
            busy      <= 1'b0;
            disp_mode <= 3'b000;
            disp_in   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cand_sel <= cand_d;
            busy     <= (state_d == StConfirm);
            case (state_d)
                StConfirm: begin
                    disp_mode <= 3'b101;
                    disp_in   <= '0;
                end
                StResults: begin
                    disp_mode <= 3'b111;
                    disp_in   <= res_val;
                end
                default: begin
                    disp_mode <= 3'b000;
                    disp_in   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Directed table-driven bench for vote_display_ctrl with NUM_CAND=3, DWELL=4, CONF=6.
module tb_vote_display_ctrl;

    localparam int unsigned NC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vote_pulse = 1'b0;
    logic          results_en = 1'b0;
    logic [15:0]   tal [3];
    logic [47:0]   tally_bus;
    logic [16:0]   disp_in;
    logic [2:0]    disp_mode;
    logic [2:0]    cand_sel;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    assign tally_bus = {tal[2], tal[1], tal[0]};

    vote_display_ctrl #(
        .NUM_CAND    (NC),
        .DWELL_CYCLES(4),
        .CONF_CYCLES (6),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vote_pulse(vote_pulse),
        .results_en(results_en),
        .tally_bus (tally_bus),
        .disp_in   (disp_in),
        .disp_mode (disp_mode),
        .cand_sel  (cand_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic        e;
        logic [2:0]  mode;
        logic [16:0] disp;
        logic [2:0]  cand;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [16:0] exp_res(input int c);
        logic [15:0] t;
        logic [3:0]  idx;
        t   = tal[c];
        idx = 4'(c + 1);
`ifdef VOTE_DISP_CAND_INDEX_EN
        return {1'b0, idx, t[11:0]};
`else
        return {1'b0, t};
`endif
    endfunction

    function automatic vec_t mk(input logic r, v, e, input logic [2:0] m,
                                input logic [16:0] d, input logic [2:0] c, input logic b);
        vec_t x;
        x.r = r; x.v = v; x.e = e; x.mode = m; x.disp = d; x.cand = c; x.busy = b;
        return x;
    endfunction

    task automatic step(input logic r, v, e);
        rst = r;
        vote_pulse = v;
        results_en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] m, input logic [16:0] d,
                       input logic [2:0] c, input logic b);
        n_checks++;
        if (disp_mode !== m || disp_in !== d || cand_sel !== c || busy !== b) begin
            n_fail++;
            $display("FAIL %s: got mode=%b disp=%h cand=%0d busy=%b, want mode=%b disp=%h cand=%0d busy=%b",
                     name, disp_mode, disp_in, cand_sel, busy, m, d, c, b);
        end
    endtask

    initial begin
        logic [16:0] e0, e1, e2;
        tal[0] = 16'h0013;
        tal[1] = 16'h0107;
        tal[2] = 16'h0042;
        e0 = exp_res(0);
        e1 = exp_res(1);
        e2 = exp_res(2);

        // Reset, results cycling with wrap, vote during results, results_en drop.
        vecs.push_back(mk(1, 0, 0, 3'b000, 17'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 3'b000, 17'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 17'h0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 3'b111, e0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 3'b111, e1, 1, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 3'b111, e2, 2, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 3'b111, e0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 3'b111, e1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 3'b101, 17'h0, 1, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 3'b101, 17'h0, 1, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 3'b111, e0, 0, 0));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 0, 1, 3'b111, e1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 17'h0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].v, vecs[i].e);
            chk($sformatf("vec%0d", i), vecs[i].mode, vecs[i].disp, vecs[i].cand, vecs[i].busy);
        end

        // Retrigger: second vote 3 cycles after the first stretches CONF to 9 cycles.
        step(0, 1, 0);
        chk("retrig_first", 3'b101, 17'h0, 0, 1);
        step(0, 0, 0);
        chk("retrig_t1", 3'b101, 17'h0, 0, 1);
        step(0, 0, 0);
        chk("retrig_t2", 3'b101, 17'h0, 0, 1);
        step(0, 1, 0);
        chk("retrig_second", 3'b101, 17'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            chk($sformatf("retrig_hold%0d", i), 3'b101, 17'h0, 0, 1);
        end
        step(0, 0, 0);
        chk("retrig_end", 3'b000, 17'h0, 0, 0);

        // Vote coincident with results_en drop: CONFIRM wins, then IDLE.
        step(0, 0, 1);
        chk("sim_res0", 3'b111, e0, 0, 0);
        step(0, 0, 1);
        chk("sim_res1", 3'b111, e0, 0, 0);
        step(0, 1, 0);
        chk("sim_vote", 3'b101, 17'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            chk($sformatf("sim_hold%0d", i), 3'b101, 17'h0, 0, 1);
        end
        step(0, 0, 0);
        chk("sim_idle", 3'b000, 17'h0, 0, 0);

        // Live tally update shows with one cycle of latency.
        step(0, 0, 1);
        chk("live_before", 3'b111, e0, 0, 0);
        tal[0] = 16'h0099;
        step(0, 0, 1);
        chk("live_after", 3'b111, exp_res(0), 0, 0);
        tal[0] = 16'h0013;
        step(0, 0, 1);
        chk("live_restore", 3'b111, e0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("pre_rst_cand1", 3'b111, e1, 1, 0);

        // Reset held two cycles mid-results.
        step(1, 0, 1);
        chk("rst_mid0", 3'b000, 17'h0, 0, 0);
        step(1, 0, 1);
        chk("rst_mid1", 3'b000, 17'h0, 0, 0);
        step(0, 0, 1);
        chk("rst_resume", 3'b111, e0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
